// File: rtl/pc_fetch_unit.sv
// Fetch-stage front end: program counter, single-outstanding instruction-memory request,
// and a one-entry instruction buffer toward decode with wrong-path response dropping.
module pc_fetch_unit #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_source,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] ind_base,
  input  logic [XLEN-1:0] ind_offset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            misalign_trap
);

  localparam logic [1:0] SrcJump = 2'd1;
  localparam logic [1:0] SrcIndj = 2'd2;

  typedef enum logic [1:0] {StIssue, StWait, StDrop, StHold} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            hold_q, hold_d;
  logic            trap_q, trap_d;

  logic            redirect;
  logic [XLEN-1:0] ind_sum;
  logic [XLEN-1:0] tgt_raw;
  logic [XLEN-1:0] tgt_pc;

  always_comb begin
    redirect = (pc_source == SrcJump) || (pc_source == SrcIndj);
    ind_sum  = ind_base + ind_offset;
    tgt_raw  = (pc_source == SrcJump) ? jump_target : {ind_sum[XLEN-1:1], 1'b0};
    // Misaligned targets still redirect; the PC drops to the enclosing word.
    tgt_pc   = {tgt_raw[XLEN-1:2], 2'b00};
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    hold_d  = hold_q;
    trap_d  = redirect & tgt_raw[1];
    unique case (state_q)
      StIssue: begin
        state_d = StWait;
        if (redirect) begin
          pc_d    = tgt_pc;
          state_d = StDrop;
        end
      end
      StWait: begin
        if (imem_rvalid && !redirect) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          hold_d  = 1'b1;
          state_d = StHold;
        end else if (imem_rvalid && redirect) begin
          pc_d    = tgt_pc;
          state_d = StIssue;
        end else if (redirect) begin
          pc_d    = tgt_pc;
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (redirect) pc_d = tgt_pc;
        if (imem_rvalid) state_d = StIssue;
      end
      StHold: begin
        if (redirect) begin
          hold_d  = 1'b0;
          pc_d    = tgt_pc;
          state_d = StIssue;
        end else if (if_ready) begin
          hold_d  = 1'b0;
          pc_d    = pc_q + XLEN'(4);
          state_d = StIssue;
        end
      end
      default: state_d = StIssue;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIssue;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      hold_q  <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      hold_q  <= hold_d;
      trap_q  <= trap_d;
    end
  end

  // Request is gated while reset is held so nothing issues before release.
  assign imem_req      = (state_q == StIssue) && !rst;
  assign imem_addr     = pc_q;
  assign if_valid      = hold_q & ~redirect;
  assign if_instr      = instr_q;
  assign if_pc         = ipc_q;
  assign misalign_trap = trap_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a latency-programmable instruction-memory responder.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_source;
  logic [31:0] jump_target, ind_base, ind_offset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        misalign_trap;

  int checks = 0;
  int errors = 0;

  // Memory responder: answers each request after mem_lat cycles with addr ^ 0xDEAD0000.
  int          mem_lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  always #5 clk = ~clk;

  assign imem_rvalid = pend && (cnt == 1) && !rst;
  assign imem_rdata  = paddr ^ 32'hDEAD_0000;

  always @(posedge clk) begin
    if (rst) pend <= 1'b0;
    else if (pend) begin
      if (cnt == 1) pend <= 1'b0;
      else cnt <= cnt - 1;
    end else if (imem_req) begin
      pend  <= 1'b1;
      cnt   <= mem_lat;
      paddr <= imem_addr;
    end
  end

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_source    (pc_source),
    .jump_target  (jump_target),
    .ind_base     (ind_base),
    .ind_offset   (ind_offset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .misalign_trap(misalign_trap)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_source = 2'd0; if_ready = 1'b0;
    jump_target = '0; ind_base = '0; ind_offset = '0;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL rst_trap: got %b want 0", misalign_trap); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
  endtask

  // NEXT-only flow, decode always ready: one instruction every 3 cycles.
  task automatic test_next();
    logic [31:0] a;
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'(i * 4);
      checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin
        errors++; $display("FAIL next_req%0d: got req=%b addr=%h want 1/%h", i, imem_req, imem_addr, a);
      end
      step();
      checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
        errors++; $display("FAIL next_wait%0d: got req=%b valid=%b want 0/0", i, imem_req, if_valid);
      end
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== a || if_instr !== (a ^ 32'hDEAD_0000)) begin
        errors++; $display("FAIL next_hold%0d: got v=%b pc=%h ins=%h want 1/%h/%h", i, if_valid, if_pc,
                           if_instr, a, a ^ 32'hDEAD_0000);
      end
      step();
    end
    if_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    step(); step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== 32'hDEAD_000C) begin
        errors++; $display("FAIL stall%0d: got v=%b pc=%h ins=%h want 1/0000000c/dead000c", i, if_valid,
                           if_pc, if_instr);
      end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d: got %b want 0", i, imem_req); end
      step();
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL stall_release: got req=%b addr=%h want 1/10", imem_req, imem_addr);
    end
  endtask

  task automatic test_jump_in_hold();
    step(); step();
    pc_source = 2'd1; jump_target = 32'h100; if_ready = 1'b1;
    #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL jump_kill: got %b want 0", if_valid); end
    step();
    pc_source = 2'd0; if_ready = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL jump_addr: got req=%b addr=%h want 1/100", imem_req, imem_addr);
    end
    checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL jump_trap: got %b want 0", misalign_trap); end
    step(); step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin
      errors++; $display("FAIL jump_deliver: got v=%b pc=%h want 1/100", if_valid, if_pc);
    end
    if_ready = 1'b1; step(); if_ready = 1'b0;
  endtask

  // INDJ while WAIT has no response yet; response arrives 3 cycles after request and is dropped.
  task automatic test_indj_drop();
    mem_lat = 3;
    step();
    pc_source = 2'd2; ind_base = 32'h2001; ind_offset = 32'h10;
    step();
    pc_source = 2'd0;
    #1;
    checks++; if (misalign_trap !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL indj_drop: got trap=%b req=%b want 0/0", misalign_trap, imem_req);
    end
    step();
    checks++; if (imem_rvalid !== 1'b1 || if_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL indj_stale: got rv=%b v=%b req=%b want 1/0/0", imem_rvalid, if_valid, imem_req);
    end
    mem_lat = 1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2010) begin
      errors++; $display("FAIL indj_addr: got req=%b addr=%h want 1/2010", imem_req, imem_addr);
    end
    step(); step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h2010 || if_instr !== 32'hDEAD_2010) begin
      errors++; $display("FAIL indj_deliver: got v=%b pc=%h ins=%h want 1/2010/dead2010", if_valid, if_pc,
                         if_instr);
    end
    if_ready = 1'b1; step(); if_ready = 1'b0;
  endtask

  // Misaligned INDJ target issued while in ISSUE.
  task automatic test_misalign();
    pc_source = 2'd2; ind_base = 32'h2000; ind_offset = 32'h6;
    step();
    pc_source = 2'd0;
    #1;
    checks++; if (misalign_trap !== 1'b1) begin errors++; $display("FAIL mis_trap: got %b want 1", misalign_trap); end
    step();
    checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b want 0", misalign_trap); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2004) begin
      errors++; $display("FAIL mis_addr: got req=%b addr=%h want 1/2004", imem_req, imem_addr);
    end
    step(); step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h2004) begin
      errors++; $display("FAIL mis_deliver: got v=%b pc=%h want 1/2004", if_valid, if_pc);
    end
    if_ready = 1'b1; step(); if_ready = 1'b0;
  endtask

  task automatic test_redirect_rvalid();
    step();
    pc_source = 2'd1; jump_target = 32'h300;
    #1;
    checks++; if (imem_rvalid !== 1'b1 || if_valid !== 1'b0) begin
      errors++; $display("FAIL rr_coinc: got rv=%b v=%b want 1/0", imem_rvalid, if_valid);
    end
    step();
    pc_source = 2'd0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || if_valid !== 1'b0) begin
      errors++; $display("FAIL rr_addr: got req=%b addr=%h v=%b want 1/300/0", imem_req, imem_addr, if_valid);
    end
    step();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rr_wait: got %b want 0", if_valid); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h300 || if_instr !== 32'hDEAD_0300) begin
      errors++; $display("FAIL rr_deliver: got v=%b pc=%h ins=%h want 1/300/dead0300", if_valid, if_pc, if_instr);
    end
    if_ready = 1'b1; step(); if_ready = 1'b0;
  endtask

  // PC wrap at the top of the address space, with reserved pc_source 3 acting as NEXT.
  task automatic test_wrap();
    step();
    pc_source = 2'd1; jump_target = 32'hFFFF_FFFC;
    step();
    pc_source = 2'd3;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_top: got req=%b addr=%h want 1/fffffffc", imem_req, imem_addr);
    end
    step(); step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h2152_FFFC) begin
      errors++; $display("FAIL wrap_deliver: got v=%b pc=%h ins=%h want 1/fffffffc/2152fffc", if_valid, if_pc,
                         if_instr);
    end
    if_ready = 1'b1; step(); if_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || misalign_trap !== 1'b0) begin
      errors++; $display("FAIL wrap_zero: got req=%b addr=%h trap=%b want 1/0/0", imem_req, imem_addr,
                         misalign_trap);
    end
  endtask

  task automatic test_reset_mid();
    pc_source = 2'd3;
    step();
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b want 0", imem_req); end
    step();
    checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
      errors++; $display("FAIL rmid_clear: got v=%b pc=%h ins=%h want 0/0/0", if_valid, if_pc, if_instr);
    end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rmid_restart: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
    step(); step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hDEAD_0000) begin
      errors++; $display("FAIL rmid_deliver: got v=%b pc=%h ins=%h want 1/0/dead0000", if_valid, if_pc, if_instr);
    end
  endtask

  initial begin
    test_reset();
    test_next();
    test_hold_stall();
    test_jump_in_hold();
    test_indj_drop();
    test_misalign();
    test_redirect_rvalid();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
